// File: rtl/alu_instruction_sequencer_pkg.sv
// Opcode constants, opcode-class helpers and sequencer state encoding
// for the ALU/MOV instruction subset.
package alu_instruction_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_FETCH_IMM,
    ST_EXEC,
    ST_WB
  } state_t;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_MOV_A_IMM = 8'h74;
  localparam logic [7:0] OP_ADD_IMM  = 8'h24;
  localparam logic [7:0] OP_SUBB_IMM = 8'h94;
  localparam logic [7:0] OP_ANL_IMM  = 8'h54;
  localparam logic [7:0] OP_ORL_IMM  = 8'h44;
  localparam logic [7:0] OP_XRL_IMM  = 8'h64;

  // Rn forms share opcode[7:3]; opcode[2:0] selects the register.
  localparam logic [4:0] RN_MOV_A      = 5'h1D;
  localparam logic [4:0] RN_MOV_RN_IMM = 5'h0F;
  localparam logic [4:0] RN_ADD        = 5'h05;
  localparam logic [4:0] RN_SUBB       = 5'h13;
  localparam logic [4:0] RN_ANL        = 5'h0B;
  localparam logic [4:0] RN_ORL        = 5'h09;
  localparam logic [4:0] RN_XRL        = 5'h0D;

  function automatic logic is_imm(input logic [7:0] op);
    return (op == OP_MOV_A_IMM) || (op == OP_ADD_IMM) || (op == OP_SUBB_IMM) ||
           (op == OP_ANL_IMM) || (op == OP_ORL_IMM) || (op == OP_XRL_IMM) ||
           (op[7:3] == RN_MOV_RN_IMM);
  endfunction

  function automatic logic is_rn(input logic [7:0] op);
    return (op[7:3] == RN_MOV_A) || (op[7:3] == RN_ADD) || (op[7:3] == RN_SUBB) ||
           (op[7:3] == RN_ANL) || (op[7:3] == RN_ORL) || (op[7:3] == RN_XRL);
  endfunction

  function automatic logic writes_carry(input logic [7:0] op);
    return (op == OP_ADD_IMM) || (op == OP_SUBB_IMM) ||
           (op[7:3] == RN_ADD) || (op[7:3] == RN_SUBB);
  endfunction

  function automatic logic writes_rn(input logic [7:0] op);
    return op[7:3] == RN_MOV_RN_IMM;
  endfunction

endpackage

// File: rtl/alu_instruction_sequencer_alu_opcode_decoder.sv
// Combinational instruction-register classifier: legality, operand source,
// and which architectural state the instruction writes back.
module alu_opcode_decoder
  import alu_instruction_sequencer_pkg::*;
(
  input  logic [7:0] ir,
  output logic       legal,
  output logic       imm,
  output logic       write_rn,
  output logic       write_carry
);

  always_comb begin
    imm         = is_imm(ir);
    legal       = imm || is_rn(ir);
    write_rn    = writes_rn(ir);
    write_carry = writes_carry(ir);
  end

endmodule

// File: rtl/alu_instruction_sequencer.sv
// Fetches ALU/MOV instructions from program ROM, sequences operands into the
// registered ALU and writes results back to ACC/PSW.C or Rn.
module alu_instruction_sequencer
  import alu_instruction_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  output logic                rom_req,
  output logic [PC_WIDTH-1:0] rom_addr,
  input  logic                rom_ack,
  input  logic [7:0]          rom_data,
  output logic [2:0]          reg_raddr,
  input  logic [7:0]          reg_rdata,
  output logic                reg_we,
  output logic [2:0]          reg_waddr,
  output logic [7:0]          reg_wdata,
  output logic [7:0]          alu_opcode,
  output logic [7:0]          alu_operand1,
  output logic [7:0]          alu_operand2,
  input  logic [8:0]          alu_result,
  input  logic                alu_psw_c,
  output logic [7:0]          acc,
  output logic                psw_c,
  output logic                instr_done,
  output logic                illegal_op
);

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          ir;
  logic                legal;
  logic                imm;
  logic                write_rn;
  logic                write_carry;
  logic                unused_result_msb;

  alu_opcode_decoder u_decoder (
    .ir          (ir),
    .legal       (legal),
    .imm         (imm),
    .write_rn    (write_rn),
    .write_carry (write_carry)
  );

  // Request is combinational so a same-cycle ack gives zero-wait fetches.
  assign rom_req   = !reset && (((state == ST_FETCH) && run) || (state == ST_FETCH_IMM));
  assign rom_addr  = pc;
  assign reg_raddr = ir[2:0];
  assign reg_waddr = ir[2:0];
  assign reg_wdata = alu_result[7:0];
  assign unused_result_msb = alu_result[8];

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_FETCH;
      pc           <= RESET_PC;
      ir           <= '0;
      acc          <= '0;
      psw_c        <= 1'b0;
      alu_opcode   <= OP_NOP;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      reg_we       <= 1'b0;
      instr_done   <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      reg_we     <= 1'b0;
      instr_done <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (rom_req && rom_ack) begin
            ir    <= rom_data;
            pc    <= pc + PC_WIDTH'(1);
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!legal) begin
            illegal_op <= 1'b1;
            state      <= ST_FETCH;
          end else if (imm) begin
            state <= ST_FETCH_IMM;
          end else begin
            alu_opcode   <= ir;
            alu_operand1 <= acc;
            alu_operand2 <= reg_rdata;
            state        <= ST_EXEC;
          end
        end
        ST_FETCH_IMM: begin
          if (rom_ack) begin
            pc           <= pc + PC_WIDTH'(1);
            alu_opcode   <= ir;
            alu_operand1 <= acc;
            alu_operand2 <= rom_data;
            state        <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Strobes are registered here so they are high during the WB cycle.
          alu_opcode <= OP_NOP;
          reg_we     <= write_rn;
          instr_done <= 1'b1;
          state      <= ST_WB;
        end
        ST_WB: begin
          if (!write_rn) acc <= alu_result[7:0];
          if (write_carry) psw_c <= alu_psw_c;
          state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_instruction_sequencer.sv
// Directed bench: ROM, register bank and registered ALU are modelled here;
// program vectors are checked for final state, timing and side effects.
module tb_alu_instruction_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic [2:0]  reg_raddr;
  logic [7:0]  reg_rdata;
  logic        reg_we;
  logic [2:0]  reg_waddr;
  logic [7:0]  reg_wdata;
  logic [7:0]  alu_opcode;
  logic [7:0]  alu_operand1;
  logic [7:0]  alu_operand2;
  logic [8:0]  alu_result = '0;
  logic        alu_psw_c = 1'b0;
  logic [7:0]  acc;
  logic        psw_c;
  logic        instr_done;
  logic        illegal_op;

  always #5 clock = ~clock;

  alu_instruction_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .rom_req      (rom_req),
    .rom_addr     (rom_addr),
    .rom_ack      (rom_ack),
    .rom_data     (rom_data),
    .reg_raddr    (reg_raddr),
    .reg_rdata    (reg_rdata),
    .reg_we       (reg_we),
    .reg_waddr    (reg_waddr),
    .reg_wdata    (reg_wdata),
    .alu_opcode   (alu_opcode),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_result   (alu_result),
    .alu_psw_c    (alu_psw_c),
    .acc          (acc),
    .psw_c        (psw_c),
    .instr_done   (instr_done),
    .illegal_op   (illegal_op)
  );

  // ROM with programmable wait states
  logic [7:0] rom [256];
  int         rom_delay = 0;
  int         wait_cnt = 0;
  assign rom_ack  = rom_req && (wait_cnt >= rom_delay);
  assign rom_data = rom[rom_addr[7:0]];
  always @(posedge clock) begin
    if (rom_req && !rom_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  int          hold_err = 0;
  logic        held = 1'b0;
  logic [15:0] held_addr = '0;
  always @(negedge clock) begin
    if (held && !(rom_req && rom_addr == held_addr)) hold_err++;
    held      = rom_req && !rom_ack && !reset;
    held_addr = rom_addr;
  end

  // Register bank: combinational read, write logged
  logic [7:0] regs [8];
  int         wr_count = 0;
  logic [2:0] last_wa = '0;
  logic [7:0] last_wd = '0;
  assign reg_rdata = regs[reg_raddr];
  always @(posedge clock) begin
    if (reg_we) begin
      regs[reg_waddr] = reg_wdata;
      wr_count++;
      last_wa = reg_waddr;
      last_wd = reg_wdata;
    end
  end

  // Registered ALU: samples at the end of EXEC, holds on opcode 00
  function automatic logic [8:0] alu_eval(input logic [7:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    casez (op)
      8'h74, 8'b11101???, 8'b01111???: return {1'b0, b};
      8'h24, 8'b00101???:              return {1'b0, a} + {1'b0, b};
      8'h94, 8'b10011???:              return {1'b0, a} - {1'b0, b};
      8'h54, 8'b01011???:              return {1'b0, a & b};
      8'h44, 8'b01001???:              return {1'b0, a | b};
      8'h64, 8'b01101???:              return {1'b0, a ^ b};
      default:                         return 9'h000;
    endcase
  endfunction

  always @(posedge clock) begin
    if (alu_opcode != 8'h00) begin
      alu_result <= alu_eval(alu_opcode, alu_operand1, alu_operand2);
      alu_psw_c  <= alu_eval(alu_opcode, alu_operand1, alu_operand2) > 9'h0FF;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [0:7][7:0] prog;
    int              delay;
    int              n_instr;
    logic [7:0]      acc;
    logic            c;
    logic [15:0]     pc;
    int              first;
    int              last;
    int              wr;
    logic [2:0]      wa;
    logic [7:0]      wd;
    int              ill;
  } vec_t;

  vec_t vecs [10];

  task automatic start_program(input logic [0:7][7:0] prog, input int delay);
    reset = 1'b1;
    run   = 1'b0;
    for (int unsigned i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int unsigned i = 0; i < 8; i++) rom[i] = prog[i];
    for (int unsigned i = 0; i < 8; i++) regs[i] = 8'h00;
    rom_delay = delay;
    wr_count  = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    run   = 1'b1;
  endtask

  task automatic run_vector(input int idx);
    vec_t v;
    int   cyc, dones, ill, first, last;
    v = vecs[idx];
    start_program(v.prog, v.delay);
    cyc = 0; dones = 0; ill = 0; first = 0; last = 0;
    while (dones < v.n_instr && cyc < 300) begin
      cyc++;
      if (illegal_op) ill++;
      if (instr_done) begin
        dones++;
        if (dones == 1) first = cyc;
        if (dones == v.n_instr) begin
          last = cyc;
          run  = 1'b0;
        end
      end
      if (dones < v.n_instr) @(negedge clock);
    end
    check($sformatf("v%0d_timeout", idx), dones, v.n_instr);
    repeat (3) begin
      @(negedge clock);
      if (illegal_op) ill++;
      if (instr_done) dones++;
    end
    check($sformatf("v%0d_acc", idx), acc, v.acc);
    check($sformatf("v%0d_psw_c", idx), psw_c, v.c);
    check($sformatf("v%0d_pc", idx), rom_addr, v.pc);
    check($sformatf("v%0d_first_done", idx), first, v.first);
    check($sformatf("v%0d_last_done", idx), last, v.last);
    check($sformatf("v%0d_done_count", idx), dones, v.n_instr);
    check($sformatf("v%0d_reg_writes", idx), wr_count, v.wr);
    check($sformatf("v%0d_illegal", idx), ill, v.ill);
    check($sformatf("v%0d_req_idle", idx), rom_req, 1'b0);
    if (v.wr > 0) begin
      check($sformatf("v%0d_waddr", idx), last_wa, v.wa);
      check($sformatf("v%0d_wdata", idx), last_wd, v.wd);
      check($sformatf("v%0d_regfile", idx), regs[v.wa], v.wd);
    end
  endtask

  initial begin
    int cyc, done_seen, req_seen, wr_before;

    vecs[0] = '{64'h7405_2403_0000_0000, 0, 2, 8'h08, 1'b0, 16'h0004,  5, 10, 0, 3'd0, 8'h00, 0};
    vecs[1] = '{64'h74F0_2420_0000_0000, 0, 2, 8'h10, 1'b1, 16'h0004,  5, 10, 0, 3'd0, 8'h00, 0};
    vecs[2] = '{64'h74F0_2420_9420_0000, 0, 3, 8'hF0, 1'b1, 16'h0006,  5, 15, 0, 3'd0, 8'h00, 0};
    vecs[3] = '{64'h7B5A_EB54_0F00_0000, 0, 3, 8'h0A, 1'b0, 16'h0005,  5, 14, 1, 3'd3, 8'h5A, 0};
    vecs[4] = '{64'hA574_0100_0000_0000, 0, 1, 8'h01, 1'b0, 16'h0003,  7,  7, 0, 3'd0, 8'h00, 1};
    vecs[5] = '{64'h7405_2403_0000_0000, 3, 2, 8'h08, 1'b0, 16'h0004, 11, 22, 0, 3'd0, 8'h00, 0};
    vecs[6] = '{64'h74F0_2420_540F_0000, 0, 3, 8'h00, 1'b1, 16'h0006,  5, 15, 0, 3'd0, 8'h00, 0};
    vecs[7] = '{64'h7A0F_74F3_4A64_FF00, 0, 4, 8'h00, 1'b0, 16'h0007,  5, 19, 1, 3'd2, 8'h0F, 0};
    vecs[8] = '{64'h7D03_7410_9D00_0000, 0, 3, 8'h0D, 1'b0, 16'h0005,  5, 14, 1, 3'd5, 8'h03, 0};
    vecs[9] = '{64'h7FFF_7401_2F00_0000, 0, 3, 8'h00, 1'b1, 16'h0005,  5, 14, 1, 3'd7, 8'hFF, 0};

    reset = 1'b1;
    run   = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_acc", acc, 8'h00);
    check("rst_psw_c", psw_c, 1'b0);
    check("rst_alu_opcode", alu_opcode, 8'h00);
    check("rst_operands", {alu_operand1, alu_operand2}, 16'h0000);
    check("rst_strobes", {rom_req, reg_we, instr_done, illegal_op}, 4'b0000);
    check("rst_pc", rom_addr, 16'h0000);

    for (int i = 0; i < 10; i++) run_vector(i);
    check("rom_req_hold", hold_err, 0);

    // Reset during EXEC of ADD abandons the instruction
    start_program(64'h7405_2403_0000_0000, 0);
    cyc = 0;
    while (alu_opcode != 8'h24 && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("exec_reached", alu_opcode, 8'h24);
    wr_before = wr_count;
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    done_seen = 0;
    req_seen  = 0;
    repeat (4) begin
      if (instr_done) done_seen++;
      if (rom_req) req_seen++;
      @(negedge clock);
    end
    check("mid_rst_acc", acc, 8'h00);
    check("mid_rst_psw_c", psw_c, 1'b0);
    check("mid_rst_no_done", done_seen, 0);
    check("mid_rst_no_req", req_seen, 0);
    check("mid_rst_no_write", wr_count, wr_before);
    check("mid_rst_pc", rom_addr, 16'h0000);
    run = 1'b1;
    #1;
    check("mid_rst_refetch", {rom_req, rom_addr}, {1'b1, 16'h0000});
    run = 1'b0;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_instruction_sequencer.md
Name: alu_instruction_sequencer

Overview:
- Initiator side of the ALU interface: fetches 8051 instruction bytes from program memory and reads Rn from the register bank.
- Presents opcode/operand1/operand2 to the arithmetic_logic_unit, waits out its one-cycle registered latency, and writes the result back to ACC or Rn.
- Owns the architectural ACC, PC and PSW.C for the supported ALU/MOV subset.
- Sits between the program ROM, the register bank and the ALU in the core datapath.

Parameters:
- PC_WIDTH, 16, program counter / ROM address width
- RESET_PC, 16'h0000, PC value after reset

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- run  in  1  permits a new instruction fetch when high
- rom_req  out  1  program-memory read request
- rom_addr  out  PC_WIDTH  byte address
- rom_ack  in  1  rom_data valid this cycle
- rom_data  in  8  instruction byte
- reg_raddr  out  3  Rn select; register bank read is combinational
- reg_rdata  in  8  Rn contents
- reg_we  out  1  Rn write strobe
- reg_waddr  out  3  Rn write select
- reg_wdata  out  8  Rn write data
- alu_opcode  out  8  opcode to ALU
- alu_operand1  out  8  always ACC
- alu_operand2  out  8  immediate or Rn
- alu_result  in  9  registered ALU result
- alu_psw_c  in  1  registered ALU carry
- acc  out  8  accumulator
- psw_c  out  1  carry flag
- instr_done  out  1  one-cycle pulse at writeback
- illegal_op  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Reset values: state=FETCH, PC=RESET_PC, acc=0, psw_c=0, alu_opcode=8'h00, operands=0, rom_req=0, reg_we=0, instr_done=0, illegal_op=0.
- Reset mid-instruction abandons the instruction: no write, no PC change after reset, rom_req low the next cycle.
- Supported opcodes (all others are illegal):
  - MOV A,#d = 74
  - MOV A,Rn = E8-EF
  - MOV Rn,#d = 78-7F
  - ADD A,#d = 24; ADD A,Rn = 28-2F
  - SUBB A,#d = 94; SUBB A,Rn = 98-9F
  - ANL A,#d = 54; ANL A,Rn = 58-5F
  - ORL A,#d = 44; ORL A,Rn = 48-4F
  - XRL A,#d = 64; XRL A,Rn = 68-6F
  - n = opcode[2:0].
- FETCH:
  - If run=1, assert rom_req with rom_addr=PC and hold both until rom_ack (ack may arrive in the same cycle).
  - On ack: IR<=rom_data, PC<=PC+1 (wraps 0xFFFF->0x0000), go to DECODE.
  - If run=0, rom_req=0 and stay.
- DECODE (1 cycle): reg_raddr=IR[2:0].
  - Illegal opcode: pulse illegal_op, go to FETCH (treated as 1-byte NOP).
  - Immediate form: go to FETCH_IMM.
  - Otherwise: latch reg_rdata as operand, go to EXEC.
- FETCH_IMM: same handshake as FETCH. On ack: operand<=rom_data, PC<=PC+1, go to EXEC.
- EXEC (1 cycle): drive alu_opcode=IR, alu_operand1=acc, alu_operand2=operand. The ALU samples these at the end of this cycle. Go to WB.
- WB (1 cycle): alu_result is now valid.
  - MOV Rn,#d: reg_we=1, reg_waddr=IR[2:0], reg_wdata=alu_result[7:0]; acc unchanged.
  - All other instructions: acc<=alu_result[7:0].
  - ADD/SUBB only: psw_c<=alu_psw_c. MOV/ANL/ORL/XRL leave psw_c unchanged.
  - SUBB does not feed carry-in; it computes A-op.
  - Pulse instr_done, set alu_opcode=8'h00 (ALU holds its result), go to FETCH.
- Outside EXEC, alu_opcode=8'h00.
- Latency with zero-wait ROM (ack same cycle as req): Rn forms 4 cycles; immediate forms 5 cycles. Each ROM wait cycle adds one cycle.
- run is sampled only in FETCH; an instruction in progress always completes.
- reg_we never asserts except in WB of MOV Rn,#d.

Decomposition:
- Shared opcodes package (the existing opcode include): exact opcode constants, Rn-form masks, opcode-class decode helpers (is_imm, is_rn, writes_carry), and state encodings.
- One natural sub-module: alu_opcode_decoder (combinational IR -> class/legal/imm flags), reused by later blocks.

Test Plan:
- ROM {74 05, 24 03}, zero-wait -> acc=08, psw_c=0; instr_done pulses at cycle 5 and cycle 10; PC=0004.
- ROM {74 F0, 24 20} -> acc=10, psw_c=1. Then {94 20} -> acc=F0, psw_c=1 (borrow).
- ROM {7B 5A, EB, 54 0F} -> reg_we with waddr=3, wdata=5A; then acc=5A; then acc=0A; psw_c unchanged.
- ROM {A5, 74 01} -> illegal_op pulses once, no reg_we, acc=01, PC=0003.
- rom_ack delayed 3 cycles on each byte -> rom_req/rom_addr held stable; results identical to the zero-wait case; latency +3 per byte.
- reset asserted in the EXEC of ADD -> acc=00, psw_c=0, no reg_we; next fetch at RESET_PC. run=0 after reset -> rom_req stays 0.
